// File: rtl/nios_send_data_tx.sv
// nios_send_data_tx: Avalon-MM slave that queues software-written words in a FIFO
// and streams them to the consumer over a registered valid/ready port.
module nios_send_data_tx #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr, wr_ptr;
    logic [ADDR_W:0]   count;
    logic [31:0]       sent;
    logic              overflow;
    logic              full, fifo_empty, xfer, load, push, flush;
    logic [7:0]        occupancy;
    logic [31:0]       rd_mux;

    assign full       = count == (ADDR_W+1)'(DEPTH);
    assign fifo_empty = count == '0;
    assign xfer       = out_valid && out_ready;
    assign load       = (!out_valid || xfer) && !fifo_empty;
    assign push       = write && address == 2'd0 && !full;
    assign flush      = write && address == 2'd2 && writedata[0];
    assign occupancy  = 8'(count) + 8'(out_valid);
    assign rd_mux     = address == 2'd0 ? (out_valid ? out_data : 32'd0) :
                        address == 2'd1 ? {16'd0, occupancy, 5'd0, overflow, fifo_empty && !out_valid, full} :
                        address == 2'd3 ? sent : 32'd0;

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            sent      <= '0;
            readdata  <= '0;
        end else begin
            readdata <= rd_mux;
            if (write && address == 2'd3)
                sent <= '0;
            else if (xfer)
                sent <= sent + 32'd1;
            if (write && address == 2'd0 && full)
                overflow <= 1'b1;
            else if (write && address == 2'd1 && writedata[2])
                overflow <= 1'b0;
            if (flush) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
                out_valid <= 1'b0;
            end else begin
                if (load) begin
                    out_data <= mem[rd_ptr];
                    rd_ptr   <= rd_ptr + ADDR_W'(1);
                end
                if (push)
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                out_valid <= load || (out_valid && !out_ready);
                count     <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(load);
            end
        end
    end
endmodule

// File: doc/nios_send_data_tx.md
# nios_send_data_tx

Avalon-MM slave transmit port for the Nios II subsystem, the outbound counterpart of the `recv_data` input PIO. Software writes 32-bit words into a small FIFO. The block presents them on a registered valid/ready stream to the external consumer (ReCOP/TDMA side), one word per handshake. Status, overflow flag and a sent-word counter are readable over the same slave.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries, power of two, at least 2.
- `ADDR_W`, default 2: log2(`DEPTH`).

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 2: Avalon register select.
- `write` in 1: Avalon write strobe, active high, zero wait states.
- `writedata` in 32: Avalon write data.
- `readdata` out 32: Avalon read data, registered.
- `out_data` out 32: stream data to the consumer, registered.
- `out_valid` out 1: `out_data` holds a word, registered.
- `out_ready` in 1: the consumer accepts the word this cycle.

## Operation
Register map:
- **0x0 DATA**
  - Write: pushes `writedata` into the FIFO if it is not full. If full, the word is dropped and the sticky overflow bit is set.
  - Read: returns the word currently on `out_data`, or 0 when `out_valid` is 0.
- **0x1 STATUS** (read)
  - bit0: full (FIFO count == `DEPTH`).
  - bit1: empty (FIFO count == 0 and `out_valid` == 0).
  - bit2: overflow.
  - bits[15:8]: occupancy = FIFO count + `out_valid` (0..`DEPTH`+1), zero-extended.
  - All other bits read 0.
- **0x1 STATUS** (write): writing bit2 = 1 clears overflow (W1C). Other bits are ignored.
- **0x2 CONTROL** (write): bit0 = 1 flushes the FIFO and the output stage. Reads return 0.
- **0x3 SENT** (read): 32-bit count of completed handshakes, wraps 0xFFFFFFFF → 0.
- **0x3 SENT** (write): any write clears the counter to 0.

Datapath:
- Circular FIFO with `ADDR_W`-bit read and write pointers and an (`ADDR_W`+1)-bit count.
- Output stage is a holding register (`out_data`, `out_valid`).
- Handshake: a transfer occurs at an edge where `out_valid` && `out_ready`.
- Output stage load: at an edge where `out_valid` == 0 or a transfer occurs, and the FIFO is non-empty, the FIFO head moves into `out_data` and `out_valid` = 1. If the FIFO is empty, `out_valid` goes to 0 and `out_data` keeps its last value.
- While `out_valid` && !`out_ready`, `out_data` and `out_valid` hold stable.
- `readdata` is loaded every cycle from the mux selected by `address`, independent of any read strobe.

Boundary rules:
- **Push and pop in the same cycle:** both take effect and the FIFO count is unchanged. A push is judged against fullness *before* that edge, so there is no pass-through credit.
- **Flush:**
  - FIFO is emptied and `out_valid` = 0 after the edge.
  - Overflow and SENT are unaffected.
  - A handshake coinciding with the flush edge still counts in SENT.
- **Push to full:** the word is dropped, count is unchanged, overflow = 1.
- **Overflow set vs clear:** a W1C clear and a new overflow cannot occur in the same cycle, since there is a single bus address per cycle.
- **Reset** (asynchronous, any time, including mid-stream):
  - `readdata`, `out_data` and SENT go to 0.
  - `out_valid` = 0, overflow = 0.
  - Pointers and count go to 0.
  - Any in-flight word is lost.

## Timing
- Avalon writes complete in one cycle with no waitrequest.
- Read latency is 1: `readdata` reflects the `address` presented at edge k after edge k.
- Push latency: a word written at edge k enters the FIFO at k. It appears on `out_data` with `out_valid` = 1 after edge k+1, provided the output stage is empty or transferring at k+1.
- Sustained throughput with `out_ready` held at 1 is one word per cycle.
- Status reads reflect state after the previous edge (one-cycle latency, same as data).

## Test plan
- **Reset:** after reset, STATUS reads 0x00000002, SENT reads 0, `out_valid` = 0 and `out_data` = 0.
- **Single word:** with `out_ready` = 1, write 0xDEADBEEF to 0x0 at edge k. Expect `out_valid` = 1 and `out_data` = 0xDEADBEEF after k+1, a handshake at k+2, `out_valid` = 0 after k+2, and SENT = 1.
- **Backpressure and overflow:**
  - Hold `out_ready` = 0 and write 1,2,3,4,5,6.
  - Expect `out_data` = 1 held stable, STATUS = full, occupancy 5, overflow = 1, and word 6 dropped.
  - Release `out_ready`: 1..5 emerge in order on consecutive cycles and SENT = 5.
- **Overflow clear:** write 0x4 to 0x1, then STATUS bit2 reads 0 and other state is unchanged.
- **Flush with pending words:** with 3 pending words and `out_ready` = 0, write 0x1 to 0x2. Expect `out_valid` = 0 and occupancy 0 next cycle. A subsequent write of 0xA5 is delivered alone.
- **Counter wrap and mid-stream reset:**
  - Preload SENT near wrap by forcing its register in the bench; after 2 transfers from 0xFFFFFFFF, SENT reads 0x00000001.
  - Assert `reset_n` mid-stream: all outputs go to 0 asynchronously and the pending FIFO data is discarded.
